// File: rtl/busca_instrucao_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package busca_instrucao_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PC_STEP = 4;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_REQ  = 2'd1,
        S_EXEC = 2'd2
    } state_t;

    // Sign-extended 16-bit immediate scaled to a byte offset.
    function automatic logic [XLEN-1:0] branch_offset(input logic [15:0] imm);
        return {{(XLEN-18){imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/busca_instrucao_calc_prox_pc.sv
// Next-PC selection: jump, then taken beq/bne, then sequential.
module calc_prox_pc
    import busca_instrucao_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] instr,
    input  logic            branch,
    input  logic            jump,
    input  logic            zero,
    output logic [XLEN-1:0] next_pc
);

    logic [XLEN-1:0] pc4;
    logic            taken;
    logic            unused_opcode_bits;

    // instr[26] separates beq (taken on zero) from bne (taken on !zero).
    assign unused_opcode_bits = ^instr[31:27];
    assign pc4   = pc + XLEN'(PC_STEP);
    assign taken = branch & (zero ^ instr[26]);

    // Priority select; jump wins over an illegal jump+branch combination.
    always_comb begin
        next_pc = pc4;
        if (jump) begin
            next_pc = {pc4[31:28], instr[25:0], 2'b00};
        end else if (taken) begin
            next_pc = pc4 + branch_offset(instr[15:0]);
        end
    end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: PC register, imem req/ack fetch FSM, held instruction.
// Optional feature macro: FETCH_PERF_COUNT_EN adds perf_instr_cnt / perf_wait_cnt.
module busca_instrucao
    import busca_instrucao_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    input  logic            exec_done,
    input  logic            branch,
    input  logic            jump,
    input  logic            zero,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] link_addr
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [31:0]     perf_instr_cnt,
    output logic [31:0]     perf_wait_cnt
`endif
);

    state_t          state, state_n;
    logic [XLEN-1:0] pc_n, instr_n, link_n, next_pc;
    logic            req_n, valid_n;

    calc_prox_pc u_calc_prox_pc (
        .pc      (pc),
        .instr   (instr),
        .branch  (branch),
        .jump    (jump),
        .zero    (zero),
        .next_pc (next_pc)
    );

    assign imem_addr = pc;

    // Next-state and next-register values; req/valid are decoded from the next state.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = instr;
        link_n  = link_addr;
        case (state)
            S_INIT: state_n = S_REQ;
            S_REQ: begin
                if (imem_ack) begin
                    instr_n = imem_rdata;
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    pc_n    = next_pc;
                    link_n  = next_pc + XLEN'(PC_STEP);
                    state_n = S_REQ;
                end
            end
            default: state_n = S_INIT;
        endcase
        req_n   = (state_n == S_REQ);
        valid_n = (state_n == S_EXEC);
    end

    // State, PC, instruction and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_INIT;
            pc          <= RESET_PC;
            link_addr   <= RESET_PC + XLEN'(PC_STEP);
            instr       <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            link_addr   <= link_n;
            instr       <= instr_n;
            imem_req    <= req_n;
            instr_valid <= valid_n;
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    // Committed-instruction and memory-wait counters, free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_instr_cnt <= '0;
            perf_wait_cnt  <= '0;
        end else begin
            if (state == S_EXEC && exec_done) begin
                perf_instr_cnt <= perf_instr_cnt + 32'd1;
            end
            if (state == S_REQ && !imem_ack) begin
                perf_wait_cnt <= perf_wait_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_busca_instrucao.sv
// Self-checking bench for busca_instrucao: directed table, hand sequences, random vs. model.
module tb_busca_instrucao;
    import busca_instrucao_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, pc, link_addr;
    logic        imem_ack, exec_done, branch, jump, zero;
    logic [31:0] imem_rdata;

    logic        t5_req, t5_valid;
    logic [31:0] t5_addr, t5_instr, t5_pc, t5_link;
    logic        t5_ack, t5_exec, t5_jump;
    logic [31:0] t5_rdata;

`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] perf_instr_cnt, perf_wait_cnt, t5_picnt, t5_pwcnt;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] m_pc;
    logic [31:0] m_icnt, m_wcnt;

    always #5 clk = ~clk;

    busca_instrucao #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .exec_done(exec_done), .branch(branch),
        .jump(jump), .zero(zero), .pc(pc), .link_addr(link_addr)
`ifdef FETCH_PERF_COUNT_EN
        , .perf_instr_cnt(perf_instr_cnt), .perf_wait_cnt(perf_wait_cnt)
`endif
    );

    busca_instrucao #(.RESET_PC(32'h1000_0004)) dut5 (
        .clk(clk), .rst_n(rst_n), .imem_req(t5_req), .imem_addr(t5_addr),
        .imem_ack(t5_ack), .imem_rdata(t5_rdata), .instr(t5_instr),
        .instr_valid(t5_valid), .exec_done(t5_exec), .branch(1'b0),
        .jump(t5_jump), .zero(1'b0), .pc(t5_pc), .link_addr(t5_link)
`ifdef FETCH_PERF_COUNT_EN
        , .perf_instr_cnt(t5_picnt), .perf_wait_cnt(t5_pwcnt)
`endif
    );

    typedef struct {
        logic [31:0] ins;
        logic        br;
        logic        jp;
        logic        zr;
        logic [31:0] exp_next;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Next PC from the ISA rules, with plain 32-bit arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
                                               input logic br, input logic jp, input logic zr);
        logic [31:0] seq;
        int          off;
        seq = p + 32'd4;
        if (jp) return (seq & 32'hF000_0000) | ({6'b0, ins[25:0]} * 32'd4);
        off = int'($signed(ins[15:0])) * 4;
        if (br && (zr != ins[26])) return seq + 32'(off);
        return seq;
    endfunction

    task automatic check_perf();
`ifdef FETCH_PERF_COUNT_EN
        check("perf_instr_cnt", perf_instr_cnt, m_icnt);
        check("perf_wait_cnt", perf_wait_cnt, m_wcnt);
`endif
    endtask

    // One fetch/execute round trip; entered and left at a negedge with the DUT in S_REQ.
    task automatic run_instr(input logic [31:0] ins, input logic br, input logic jp,
                             input logic zr, input logic [31:0] exp_next,
                             input int ack_wait, input int exec_wait, input logic noise);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", 32'(imem_req), 32'd1);
        check("fetch_addr", imem_addr, m_pc);
        for (int i = 0; i < ack_wait; i++) begin
            imem_ack  = 1'b0;
            exec_done = noise & 1'($urandom);
            @(negedge clk);
            m_wcnt = m_wcnt + 32'd1;
            check("addr_stable", imem_addr, m_pc);
            check("wait_no_valid", 32'(instr_valid), 32'd0);
        end
        exec_done  = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = ins;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        check("instr_valid", 32'(instr_valid), 32'd1);
        check("instr", instr, ins);
        check("req_dropped", 32'(imem_req), 32'd0);
        check("link_addr", link_addr, m_pc + 32'd4);
        for (int i = 0; i < exec_wait; i++) begin
            imem_ack = noise & 1'($urandom);
            @(negedge clk);
            check("instr_held", instr, ins);
        end
        imem_ack  = 1'b0;
        exec_done = 1'b1;
        branch    = br;
        jump      = jp;
        zero      = zr;
        @(negedge clk);
        exec_done = 1'b0;
        branch    = 1'($urandom);
        jump      = 1'($urandom);
        zero      = 1'($urandom);
        m_pc      = exp_next;
        m_icnt    = m_icnt + 32'd1;
        check("next_pc", pc, m_pc);
        check("req_after_exec", 32'(imem_req), 32'd1);
        check("valid_after_exec", 32'(instr_valid), 32'd0);
        check_perf();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins, nxt;
        logic        br, jp, zr;
        int          sel;

        tbl[0]  = '{32'h0800_0004, 1'b0, 1'b1, 1'b0, 32'h0000_0010};
        tbl[1]  = '{32'h1000_0003, 1'b1, 1'b0, 1'b1, 32'h0000_0020};
        tbl[2]  = '{32'h0800_0004, 1'b0, 1'b1, 1'b0, 32'h0000_0010};
        tbl[3]  = '{32'h1000_0003, 1'b1, 1'b0, 1'b0, 32'h0000_0014};
        tbl[4]  = '{32'h0800_0002, 1'b0, 1'b1, 1'b0, 32'h0000_0008};
        tbl[5]  = '{32'h1400_FFFF, 1'b1, 1'b0, 1'b0, 32'h0000_0008};
        tbl[6]  = '{32'h1400_FFFF, 1'b1, 1'b0, 1'b1, 32'h0000_000C};
        tbl[7]  = '{32'h1000_0003, 1'b1, 1'b1, 1'b1, 32'h0000_000C};
        tbl[8]  = '{32'h1400_FFFD, 1'b0, 1'b0, 1'b0, 32'h0000_0010};
        tbl[9]  = '{32'h1400_FFFB, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
        tbl[10] = '{32'h1400_FFFE, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC};
        tbl[11] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
        tbl[12] = '{32'h0C00_0010, 1'b0, 1'b1, 1'b0, 32'h0000_0040};

        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; exec_done = 1'b0;
        branch = 1'b0; jump = 1'b0; zero = 1'b0;
        t5_ack = 1'b0; t5_rdata = '0; t5_exec = 1'b0; t5_jump = 1'b0;
        m_pc = 32'h0; m_icnt = '0; m_wcnt = '0;

        // T1: reset held two cycles, S_INIT for one cycle after release.
        repeat (2) begin
            @(negedge clk);
            check("rst_req", 32'(imem_req), 32'd0);
            check("rst_valid", 32'(instr_valid), 32'd0);
            check("rst_pc", pc, 32'h0);
            check("rst_instr", instr, 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("req_after_release", 32'(imem_req), 32'd1);
        check("addr_after_release", imem_addr, 32'h0);
        check_perf();

        // T5: jal from a high PC on the second instance.
        t5_ack = 1'b1; t5_rdata = 32'h0C00_0010;
        @(negedge clk);
        t5_ack = 1'b0;
        check("t5_valid", 32'(t5_valid), 32'd1);
        check("t5_link", t5_link, 32'h1000_0008);
        t5_exec = 1'b1; t5_jump = 1'b1;
        @(negedge clk);
        t5_exec = 1'b0; t5_jump = 1'b0;
        check("t5_pc", t5_pc, 32'h1000_0040);
        check("t5_req", 32'(t5_req), 32'd1);

        // T2: three wait states on the first fetch.
        run_instr(32'h2008_0005, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 3, 0, 1'b1);

        // Directed table: beq/bne both ways, backward/wrap, jump priority, jal.
        foreach (tbl[i]) begin
            run_instr(tbl[i].ins, tbl[i].br, tbl[i].jp, tbl[i].zr, tbl[i].exp_next,
                      i % 3, i % 2, 1'b1);
        end

        // T6: reset while a request is outstanding, then a late ack in S_INIT.
        imem_ack = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_req", 32'(imem_req), 32'd0);
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_instr", instr, 32'h0);
        rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        check("late_ack_valid", 32'(instr_valid), 32'd0);
        check("late_ack_req", 32'(imem_req), 32'd1);
        repeat (2) begin
            @(negedge clk);
            check("no_fresh_ack_valid", 32'(instr_valid), 32'd0);
        end
        m_pc = 32'h0; m_icnt = '0; m_wcnt = 32'd2;
        check_perf();
        run_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 1, 0, 1'b0);

        // Random phase against the reference model.
        for (int k = 0; k < 200; k++) begin
            ins = $urandom;
            br  = 1'($urandom);
            jp  = 1'b0;
            zr  = 1'($urandom);
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: jp = 1'b1;
                1: begin ins[31:26] = OP_BEQ; br = 1'b1; end
                2: begin ins[31:26] = OP_BNE; br = 1'b1; end
                default: ;
            endcase
            nxt = model_next(m_pc, ins, br, jp, zr);
            run_instr(ins, br, jp, zr, nxt, int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
